// File: rtl/uart_tx.sv
// uart_tx: frames a parallel word as start, LSB-first data, optional even parity and stop bit
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_stb,
  input  logic                  i_div_clk_rose,
  output logic                  o_div_start_stb,
  output logic                  o_div_reset_stb,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done_stb
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   shift, shift_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    par, par_nxt;
  logic                    tx_nxt, busy_nxt, start_nxt, div_rst_nxt, done_nxt;
  // State, datapath and every output are registered; reset abandons any frame silently
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= IDLE;
      shift           <= '0;
      cnt             <= '0;
      par             <= 1'b0;
      o_tx            <= 1'b1;
      o_busy          <= 1'b0;
      o_div_start_stb <= 1'b0;
      o_div_reset_stb <= 1'b0;
      o_done_stb      <= 1'b0;
    end else begin
      state           <= state_nxt;
      shift           <= shift_nxt;
      cnt             <= cnt_nxt;
      par             <= par_nxt;
      o_tx            <= tx_nxt;
      o_busy          <= busy_nxt;
      o_div_start_stb <= start_nxt;
      o_div_reset_stb <= div_rst_nxt;
      o_done_stb      <= done_nxt;
    end
  end
  // Next-state and next-output logic; parity is captured at accept so shifting cannot disturb it
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    cnt_nxt     = cnt;
    par_nxt     = par;
    tx_nxt      = o_tx;
    busy_nxt    = o_busy;
    start_nxt   = 1'b0;
    div_rst_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (i_data_stb) begin
          shift_nxt = i_data;
          cnt_nxt   = '0;
          par_nxt   = ^i_data;
          state_nxt = START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          start_nxt = 1'b1;
        end
      end
      START: if (i_div_clk_rose) begin
        tx_nxt    = shift[0];
        state_nxt = DATA;
      end
      DATA: if (i_div_clk_rose) begin
        if (cnt < CW'(DATA_WIDTH - 1)) begin
          shift_nxt = shift >> 1;
          tx_nxt    = shift[1];
          cnt_nxt   = cnt + CW'(1);
        end else begin
          tx_nxt    = PARITY_EN ? par : 1'b1;
          state_nxt = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: if (i_div_clk_rose) begin
        tx_nxt    = 1'b1;
        state_nxt = STOP;
      end
      STOP: if (i_div_clk_rose) begin
        state_nxt   = IDLE;
        div_rst_nxt = 1'b1;
        done_nxt    = 1'b1;
        busy_nxt    = 1'b0;
        tx_nxt      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx with and without parity
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [1:0] stb = 2'b00, tick = 2'b00;
  logic [1:0] tx, busy, ss, rs, ds;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b0)) u0 (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_data_stb(stb[0]), .i_div_clk_rose(tick[0]),
    .o_div_start_stb(ss[0]), .o_div_reset_stb(rs[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done_stb(ds[0]));
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1'b1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_data_stb(stb[1]), .i_div_clk_rose(tick[1]),
    .o_div_start_stb(ss[1]), .o_div_reset_stb(rs[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done_stb(ds[1]));

  task automatic strobe(input int p, input logic [7:0] d);
    data = d;
    stb[p] = 1'b1;
    @(negedge clk);
    stb[p] = 1'b0;
  endtask

  // Outputs compared as {tx, busy, start_stb, reset_stb, done_stb}; 20 cycles per bit
  task automatic run_frame(input int p, input int nb, input logic [10:0] exp, input int ign_k,
                           input int abort_k, input bit chain, input logic [7:0] nxt);
    logic [4:0] want;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < 20; c++) begin
        if (k == abort_k && c == 5) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          n_cmp++;
          if ({tx[p], busy[p], ss[p], rs[p], ds[p]} !== 5'b10000) begin
            n_bad++;
            $display("FAIL abort p=%0d got=%b want=10000", p, {tx[p], busy[p], ss[p], rs[p], ds[p]});
          end
          return;
        end
        want = {exp[k], 1'b1, (k == 0 && c == 0), 2'b00};
        n_cmp++;
        if ({tx[p], busy[p], ss[p], rs[p], ds[p]} !== want) begin
          n_bad++;
          $display("FAIL frame p=%0d bit=%0d cyc=%0d got=%b want=%b", p, k, c, {tx[p], busy[p], ss[p], rs[p], ds[p]}, want);
        end
        if (k == ign_k && c == 7) begin
          data = 8'hA3;
          stb[p] = 1'b1;
        end
        if (c == 19) begin
          tick[p] = 1'b1;
          if (ign_k >= 0 && k == nb - 1) begin
            data = 8'hA3;
            stb[p] = 1'b1;
          end
        end
        @(negedge clk);
        stb[p] = 1'b0;
        tick[p] = 1'b0;
      end
    end
    n_cmp++;
    if ({tx[p], busy[p], ss[p], rs[p], ds[p]} !== 5'b10011) begin
      n_bad++;
      $display("FAIL done p=%0d got=%b want=10011", p, {tx[p], busy[p], ss[p], rs[p], ds[p]});
    end
    if (chain) begin
      strobe(p, nxt);
    end else begin
      @(negedge clk);
      n_cmp++;
      if ({tx[p], busy[p], ss[p], rs[p], ds[p]} !== 5'b10000) begin
        n_bad++;
        $display("FAIL post_idle p=%0d got=%b want=10000", p, {tx[p], busy[p], ss[p], rs[p], ds[p]});
      end
    end
  endtask

  task automatic test_reset;
    data = 8'hFF;
    stb = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stb = 2'b00;
    for (int i = 0; i < 50; i++) begin
      tick = 2'($urandom_range(0, 3));
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        n_cmp++;
        if ({tx[p], busy[p], ss[p], rs[p], ds[p]} !== 5'b10000) begin
          n_bad++;
          $display("FAIL idle p=%0d cyc=%0d got=%b want=10000", p, i, {tx[p], busy[p], ss[p], rs[p], ds[p]});
        end
      end
    end
    tick = 2'b00;
  endtask

  task automatic test_send_55;
    strobe(0, 8'h55);
    run_frame(0, 10, 11'h2AA, -1, -1, 1'b0, 8'h00);
  endtask

  task automatic test_parity;
    strobe(1, 8'h07);
    run_frame(1, 11, 11'h60E, -1, -1, 1'b0, 8'h00);
    strobe(1, 8'h55);
    run_frame(1, 11, 11'h4AA, -1, -1, 1'b0, 8'h00);
  endtask

  task automatic test_ignore_busy;
    strobe(0, 8'h0F);
    run_frame(0, 10, 11'h21E, 4, -1, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back;
    strobe(0, 8'h81);
    run_frame(0, 10, 11'h302, -1, -1, 1'b1, 8'h7E);
    run_frame(0, 10, 11'h2FC, -1, -1, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid;
    strobe(0, 8'hFF);
    run_frame(0, 10, 11'h3FE, -1, 4, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick[0] = 1'b1;
      @(negedge clk);
      tick[0] = 1'b0;
      n_cmp++;
      if ({tx[0], busy[0], ss[0], rs[0], ds[0]} !== 5'b10000) begin
        n_bad++;
        $display("FAIL after_abort cyc=%0d got=%b want=10000", i, {tx[0], busy[0], ss[0], rs[0], ds[0]});
      end
    end
    strobe(0, 8'h01);
    run_frame(0, 10, 11'h202, -1, -1, 1'b0, 8'h00);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_send_55;
    test_parity;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
